// File: rtl/dipole_sweep_sched_if.sv
// Request/acknowledge bundle between a sweep requester and the dipole sweep scheduler.
interface dipole_sweep_sched_if #(
  parameter int PASS_W = 4
);
  logic              req_valid;
  logic              req_ready;
  logic              resp_aborted;
  logic              busy;
  logic              abort;
  logic [PASS_W-1:0] passes;

  modport master (
    output req_valid, abort, passes,
    input  req_ready, resp_aborted, busy
  );

  modport slave (
    input  req_valid, abort, passes,
    output req_ready, resp_aborted, busy
  );
endinterface

// File: rtl/dipole_sweep_sched.sv
// Sweep scheduler for the dipole write array: walks NL interleaved lanes over a latched area,
// overlays a strobed write window and commits lane results, with multi-pass, abort and cycle count.
module dipole_sweep_sched #(
  parameter int AREA_W  = 16,
  parameter int AREA_H  = 16,
  parameter int LANES_X = 8,
  parameter int LANES_Y = 4,
  parameter int WIN_X   = 4,
  parameter int WIN_Y   = 4,
  parameter int WIN_W   = 8,
  parameter int WIN_H   = 8,
  parameter int PASS_W  = 4,
  parameter int CNT_W   = 16,
  localparam int XW = $clog2(AREA_W),
  localparam int YW = $clog2(AREA_H),
  localparam int NL = LANES_X * LANES_Y,
  localparam int NA = AREA_W * AREA_H,
  localparam int NW = WIN_W * WIN_H
) (
  input  logic                 clk,
  input  logic                 resetn,
  dipole_sweep_sched_if.slave  req_bus,
  input  logic [XW-1:0]        i_axlo,
  input  logic [XW-1:0]        i_axhi,
  input  logic [YW-1:0]        i_aylo,
  input  logic [YW-1:0]        i_ayhi,
  input  logic [NA-1:0]        i_area_in,
  output logic [NA-1:0]        o_area_out,
  input  logic [NW-1:0]        i_wr_strobe,
  input  logic [NW-1:0]        i_wr_data,
  output logic [NL-1:0]        o_lane_valid,
  input  logic [NL-1:0]        i_lane_ready,
  input  logic [NL-1:0]        i_lane_update,
  input  logic [NL-1:0]        i_lane_value,
  output logic [NL*XW-1:0]     o_lane_x,
  output logic [NL*YW-1:0]     o_lane_y,
  output logic [CNT_W-1:0]     o_cycle_count
);

  localparam int CX = AREA_W / LANES_X;
  localparam int CY = AREA_H / LANES_Y;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PROC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Position-0 coordinates of every lane; the pass restart point.
  function automatic logic [NL*XW-1:0] base_x_f();
    logic [NL*XW-1:0] v;
    v = '0;
    for (int i = 0; i < NL; i++) v[i*XW +: XW] = XW'(i % LANES_X);
    return v;
  endfunction

  function automatic logic [NL*YW-1:0] base_y_f();
    logic [NL*YW-1:0] v;
    v = '0;
    for (int i = 0; i < NL; i++) v[i*YW +: YW] = YW'(i / LANES_X);
    return v;
  endfunction

  localparam logic [NL*XW-1:0] BASE_X = base_x_f();
  localparam logic [NL*YW-1:0] BASE_Y = base_y_f();

  state_t            r_state, w_state_nxt;
  logic [NA-1:0]     r_area, w_area_nxt;
  logic [NL-1:0]     r_done, w_done_nxt;
  logic [NL*XW-1:0]  r_lane_x, w_lane_x_nxt;
  logic [NL*YW-1:0]  r_lane_y, w_lane_y_nxt;
  logic [PASS_W-1:0] r_pass, w_pass_nxt;
  logic [PASS_W-1:0] r_passes, w_passes_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_aborted, w_aborted_nxt;
  logic              r_req_ready, r_busy;
  logic [NL-1:0]     w_lane_valid;
  logic [XW-1:0]     w_x;
  logic [YW-1:0]     w_y;
  logic              w_in_win, w_adv;
  int                w_cidx, w_widx;

  // Next-state, area update and lane stepping.
  always_comb begin
    w_state_nxt   = r_state;
    w_area_nxt    = r_area;
    w_done_nxt    = r_done;
    w_lane_x_nxt  = r_lane_x;
    w_lane_y_nxt  = r_lane_y;
    w_pass_nxt    = r_pass;
    w_passes_nxt  = r_passes;
    w_cnt_nxt     = r_cnt;
    w_aborted_nxt = r_aborted;
    w_lane_valid  = '0;
    w_x           = '0;
    w_y           = '0;
    w_in_win      = 1'b0;
    w_adv         = 1'b0;
    w_cidx        = 0;
    w_widx        = 0;
    case (r_state)
      S_IDLE: begin
        if (req_bus.req_valid) begin
          w_state_nxt   = S_PROC;
          w_area_nxt    = i_area_in;
          w_passes_nxt  = (req_bus.passes == '0) ? {{(PASS_W-1){1'b0}}, 1'b1} : req_bus.passes;
          w_pass_nxt    = '0;
          w_done_nxt    = '0;
          w_cnt_nxt     = '0;
          w_aborted_nxt = 1'b0;
          w_lane_x_nxt  = BASE_X;
          w_lane_y_nxt  = BASE_Y;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_PROC: begin
        w_cnt_nxt = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        if (req_bus.abort) begin
          w_aborted_nxt = 1'b1;
          w_state_nxt   = S_DONE;
        end else begin
          for (int i = 0; i < NL; i++) begin
            w_x      = r_lane_x[i*XW +: XW];
            w_y      = r_lane_y[i*YW +: YW];
            w_cidx   = int'(w_y) * AREA_W + int'(w_x);
            w_in_win = (int'(w_x) >= WIN_X) && (int'(w_x) < WIN_X + WIN_W) &&
                       (int'(w_y) >= WIN_Y) && (int'(w_y) < WIN_Y + WIN_H);
            w_widx   = w_in_win ? (int'(w_y) - WIN_Y) * WIN_W + (int'(w_x) - WIN_X) : 0;
            w_adv    = 1'b0;
            if (!r_done[i]) begin
              if (w_in_win && i_wr_strobe[w_widx]) begin
                w_area_nxt[w_cidx] = i_wr_data[w_widx];
                w_adv              = 1'b1;
              end else begin
                w_lane_valid[i] = (w_x >= i_axlo) && (w_x <= i_axhi) &&
                                  (w_y >= i_aylo) && (w_y <= i_ayhi);
                w_adv           = i_lane_ready[i] || !w_lane_valid[i];
                if (w_lane_valid[i] && i_lane_ready[i] && i_lane_update[i]) begin
                  w_area_nxt[w_cidx] = i_lane_value[i];
                end else begin
                  w_area_nxt[w_cidx] = w_area_nxt[w_cidx];
                end
              end
            end else begin
              w_adv = 1'b0;
            end
            // Last position is the bottom-right cell of the lane's interleaved set.
            if (w_adv) begin
              if (w_x == XW'((i % LANES_X) + LANES_X * (CX - 1)) &&
                  w_y == YW'((i / LANES_X) + LANES_Y * (CY - 1))) begin
                w_done_nxt[i] = 1'b1;
              end else if (w_x == XW'((i % LANES_X) + LANES_X * (CX - 1))) begin
                w_lane_x_nxt[i*XW +: XW] = XW'(i % LANES_X);
                w_lane_y_nxt[i*YW +: YW] = w_y + YW'(LANES_Y);
              end else begin
                w_lane_x_nxt[i*XW +: XW] = w_x + XW'(LANES_X);
              end
            end else begin
              w_done_nxt[i] = w_done_nxt[i];
            end
          end
          if (&w_done_nxt) begin
            if (({1'b0, r_pass} + {{PASS_W{1'b0}}, 1'b1}) < {1'b0, r_passes}) begin
              w_pass_nxt   = r_pass + {{(PASS_W-1){1'b0}}, 1'b1};
              w_done_nxt   = '0;
              w_lane_x_nxt = BASE_X;
              w_lane_y_nxt = BASE_Y;
            end else begin
              w_state_nxt = S_DONE;
            end
          end else begin
            w_state_nxt = S_PROC;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; completion pulse and busy are registered from next state.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_area      <= '0;
      r_done      <= '0;
      r_lane_x    <= BASE_X;
      r_lane_y    <= BASE_Y;
      r_pass      <= '0;
      r_passes    <= '0;
      r_cnt       <= '0;
      r_aborted   <= 1'b0;
      r_req_ready <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_area      <= w_area_nxt;
      r_done      <= w_done_nxt;
      r_lane_x    <= w_lane_x_nxt;
      r_lane_y    <= w_lane_y_nxt;
      r_pass      <= w_pass_nxt;
      r_passes    <= w_passes_nxt;
      r_cnt       <= w_cnt_nxt;
      r_aborted   <= w_aborted_nxt;
      r_req_ready <= (w_state_nxt == S_DONE);
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

  assign req_bus.req_ready    = r_req_ready;
  assign req_bus.resp_aborted = r_aborted;
  assign req_bus.busy         = r_busy;
  assign o_area_out           = r_area;
  assign o_lane_valid         = w_lane_valid;
  assign o_lane_x             = r_lane_x;
  assign o_lane_y             = r_lane_y;
  assign o_cycle_count        = r_cnt;

endmodule

// File: tb/tb_dipole_sweep_sched.sv
// Randomised self-checking bench for dipole_sweep_sched against a position-list reference model.
module tb_dipole_sweep_sched;
  localparam int AREA_W = 16, AREA_H = 16, LANES_X = 8, LANES_Y = 4;
  localparam int WIN_X = 4, WIN_Y = 4, WIN_W = 8, WIN_H = 8, PASS_W = 4, CNT_W = 16;
  localparam int XW = $clog2(AREA_W), YW = $clog2(AREA_H), NL = LANES_X * LANES_Y;
  localparam int NA = AREA_W * AREA_H, NW = WIN_W * WIN_H;
  localparam int CX = AREA_W / LANES_X, CY = AREA_H / LANES_Y, S = CX * CY;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  dipole_sweep_sched_if #(.PASS_W(PASS_W)) bus();
  logic [XW-1:0] axlo, axhi;
  logic [YW-1:0] aylo, ayhi;
  logic [NA-1:0] area_in, area_out;
  logic [NW-1:0] wr_strobe, wr_data;
  logic [NL-1:0] lane_valid, lane_ready, lane_update, lane_value;
  logic [NL*XW-1:0] lane_x;
  logic [NL*YW-1:0] lane_y;
  logic [CNT_W-1:0] cycle_count;

  dipole_sweep_sched #(
    .AREA_W(AREA_W), .AREA_H(AREA_H), .LANES_X(LANES_X), .LANES_Y(LANES_Y),
    .WIN_X(WIN_X), .WIN_Y(WIN_Y), .WIN_W(WIN_W), .WIN_H(WIN_H),
    .PASS_W(PASS_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .resetn(resetn), .req_bus(bus),
    .i_axlo(axlo), .i_axhi(axhi), .i_aylo(aylo), .i_ayhi(ayhi),
    .i_area_in(area_in), .o_area_out(area_out),
    .i_wr_strobe(wr_strobe), .i_wr_data(wr_data),
    .o_lane_valid(lane_valid), .i_lane_ready(lane_ready),
    .i_lane_update(lane_update), .i_lane_value(lane_value),
    .o_lane_x(lane_x), .o_lane_y(lane_y), .o_cycle_count(cycle_count)
  );

  int n_tests = 0;
  int n_fail = 0;

  logic [NA-1:0]    obs_area, exp_area;
  logic [CNT_W-1:0] obs_cnt;
  int               exp_cnt, lane_mism;
  logic             obs_ready, obs_aborted, exp_aborted, obs_ready_after, obs_busy_after, lv_seen;

  function automatic logic [NA-1:0] rand_area();
    logic [NA-1:0] v;
    for (int j = 0; j < NA / 32; j++) v[j*32 +: 32] = $urandom;
    return v;
  endfunction

  // Cell index of lane i at sweep position p.
  function automatic int cell_of(input int i, input int p);
    return ((i / LANES_X) + LANES_Y * (p / CX)) * AREA_W + (i % LANES_X) + LANES_X * (p % CX);
  endfunction

  function automatic int lane_xpos(input int i, input int p);
    return (i % LANES_X) + LANES_X * (p % CX);
  endfunction

  function automatic int lane_ypos(input int i, input int p);
    return (i / LANES_X) + LANES_Y * (p / CX);
  endfunction

  task automatic set_bounds(input int xl, input int xh, input int yl, input int yh);
    axlo = XW'(xl); axhi = XW'(xh); aylo = YW'(yl); ayhi = YW'(yh);
  endtask

  // Runs one request while a reference model tracks each lane's position list.
  // mode 0: random lane responses; 1: all lanes ready/update/value=1; 2: as 1 but lane0 stalls 5 cycles.
  task automatic run_sweep(input logic [NA-1:0] a_in, input logic [PASS_W-1:0] np,
                           input int mode, input int abort_at);
    int pos[NL];
    bit dn[NL];
    int pass, npass, k, x, y, c, w;
    bit fin, valid, adv, inwin, all;
    exp_area = a_in; npass = (np == 0) ? 1 : int'(np); pass = 0; k = 0; fin = 1'b0;
    exp_cnt = 0; exp_aborted = 1'b0; lane_mism = 0; lv_seen = 1'b0;
    for (int i = 0; i < NL; i++) begin pos[i] = 0; dn[i] = 1'b0; end
    @(negedge clk);
    area_in = a_in; bus.passes = np; bus.req_valid = 1'b1; bus.abort = 1'b0;
    while (!fin && k < 4000) begin
      @(negedge clk);
      k++;
      if (mode == 0) begin
        lane_ready = NL'($urandom); lane_update = NL'($urandom); lane_value = NL'($urandom);
      end else begin
        lane_ready = '1; lane_update = '1; lane_value = '1;
        if (mode == 2 && k <= 5) lane_ready[0] = 1'b0;
      end
      bus.abort = (k == abort_at);
      #1;
      lv_seen = lv_seen | (|lane_valid);
      exp_cnt++;
      if (bus.abort) begin
        exp_aborted = 1'b1;
        fin = 1'b1;
        if (lane_valid !== '0) lane_mism++;
      end else begin
        for (int i = 0; i < NL; i++) begin
          x = lane_xpos(i, pos[i]); y = lane_ypos(i, pos[i]); c = cell_of(i, pos[i]);
          if (lane_x[i*XW +: XW] !== XW'(x) || lane_y[i*YW +: YW] !== YW'(y)) lane_mism++;
          valid = 1'b0;
          if (!dn[i]) begin
            inwin = x >= WIN_X && x < WIN_X + WIN_W && y >= WIN_Y && y < WIN_Y + WIN_H;
            w = inwin ? (y - WIN_Y) * WIN_W + (x - WIN_X) : 0;
            if (inwin && wr_strobe[w]) begin
              exp_area[c] = wr_data[w];
              adv = 1'b1;
            end else begin
              valid = x >= int'(axlo) && x <= int'(axhi) && y >= int'(aylo) && y <= int'(ayhi);
              if (valid && lane_ready[i] && lane_update[i]) exp_area[c] = lane_value[i];
              adv = !valid || lane_ready[i];
            end
            if (adv) begin
              if (pos[i] == S - 1) dn[i] = 1'b1;
              else pos[i]++;
            end
          end
          if (lane_valid[i] !== valid) lane_mism++;
        end
        all = 1'b1;
        for (int i = 0; i < NL; i++) all = all & dn[i];
        if (all) begin
          if (pass + 1 < npass) begin
            pass++;
            for (int i = 0; i < NL; i++) begin pos[i] = 0; dn[i] = 1'b0; end
          end else begin
            fin = 1'b1;
          end
        end
      end
    end
    if (!fin) lane_mism++;
    @(negedge clk);
    obs_ready = bus.req_ready; obs_aborted = bus.resp_aborted; obs_cnt = cycle_count; obs_area = area_out;
    bus.req_valid = 1'b0; bus.abort = 1'b0; lane_ready = '0; lane_update = '0; lane_value = '0;
    @(negedge clk);
    obs_ready_after = bus.req_ready; obs_busy_after = bus.busy;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({bus.busy, bus.req_ready, bus.resp_aborted} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 000", {bus.busy, bus.req_ready, bus.resp_aborted});
    end
    n_tests++;
    if (area_out !== '0 || cycle_count !== '0 || lane_valid !== '0) begin
      n_fail++; $display("FAIL reset_regs: area=%h cnt=%0d lv=%h expected all 0", area_out, cycle_count, lane_valid);
    end
    n_tests++;
    if (lane_x[5*XW +: XW] !== XW'(5) || lane_y[13*YW +: YW] !== YW'(1)) begin
      n_fail++; $display("FAIL reset_coords: got x5=%0d y13=%0d expected 5 1", lane_x[5*XW +: XW], lane_y[13*YW +: YW]);
    end
    resetn = 1'b1;
  endtask

  task automatic test_empty_bounds();
    logic [NA-1:0] a;
    a = rand_area();
    set_bounds(15, 0, 0, 15); wr_strobe = '0; wr_data = '1;
    run_sweep(a, 4'd1, 0, 0);
    n_tests++;
    if (obs_ready !== 1'b1 || obs_ready_after !== 1'b0 || obs_busy_after !== 1'b0) begin
      n_fail++; $display("FAIL empty_timing: ready=%b after=%b busy=%b expected 1 0 0", obs_ready, obs_ready_after, obs_busy_after);
    end
    n_tests++;
    if (obs_cnt !== 16'd8) begin n_fail++; $display("FAIL empty_count: got %0d expected 8", obs_cnt); end
    n_tests++;
    if (obs_area !== a || lv_seen !== 1'b0) begin
      n_fail++; $display("FAIL empty_area: area=%h lv_seen=%b expected %h 0", obs_area, lv_seen, a);
    end
  endtask

  task automatic test_full_commit();
    set_bounds(0, 15, 0, 15); wr_strobe = '0; wr_data = '0;
    run_sweep('0, 4'd1, 1, 0);
    n_tests++;
    if (obs_area !== {NA{1'b1}} || obs_cnt !== 16'd8 || obs_ready !== 1'b1) begin
      n_fail++; $display("FAIL full_commit: area=%h cnt=%0d ready=%b expected all ones 8 1", obs_area, obs_cnt, obs_ready);
    end
    n_tests++;
    if (lane_mism != 0) begin n_fail++; $display("FAIL full_lanes: got %0d lane errors expected 0", lane_mism); end
  endtask

  task automatic test_lane_stall();
    set_bounds(0, 15, 0, 15); wr_strobe = '0;
    run_sweep('0, 4'd1, 2, 0);
    n_tests++;
    if (obs_cnt !== 16'd13 || obs_area !== {NA{1'b1}} || lane_mism != 0) begin
      n_fail++; $display("FAIL lane_stall: cnt=%0d area=%h errs=%0d expected 13 all-ones 0", obs_cnt, obs_area, lane_mism);
    end
  endtask

  task automatic test_window();
    logic [NA-1:0] e;
    logic [63:0] pat;
    pat = 64'hA5A5_A5A5_A5A5_A5A5;
    set_bounds(0, 15, 0, 15); wr_strobe = '1; wr_data = pat;
    for (int y = 0; y < AREA_H; y++)
      for (int x = 0; x < AREA_W; x++)
        e[y*AREA_W + x] = (x >= WIN_X && x < WIN_X + WIN_W && y >= WIN_Y && y < WIN_Y + WIN_H) ?
                          pat[(y - WIN_Y) * WIN_W + (x - WIN_X)] : 1'b1;
    run_sweep(rand_area(), 4'd1, 1, 0);
    n_tests++;
    if (obs_area !== e) begin n_fail++; $display("FAIL window_area: got %h expected %h", obs_area, e); end
    n_tests++;
    if (lane_mism != 0) begin n_fail++; $display("FAIL window_lanes: got %0d lane errors expected 0", lane_mism); end
  endtask

  task automatic test_passes();
    set_bounds(15, 0, 15, 0); wr_strobe = '0;
    run_sweep(rand_area(), 4'd3, 0, 0);
    n_tests++;
    if (obs_cnt !== 16'd24 || obs_ready !== 1'b1) begin
      n_fail++; $display("FAIL passes3: cnt=%0d ready=%b expected 24 1", obs_cnt, obs_ready);
    end
    run_sweep(rand_area(), 4'd0, 0, 0);
    n_tests++;
    if (obs_cnt !== 16'd8 || obs_ready !== 1'b1) begin
      n_fail++; $display("FAIL passes0: cnt=%0d ready=%b expected 8 1", obs_cnt, obs_ready);
    end
  endtask

  task automatic test_abort();
    logic [NA-1:0] a, e;
    a = rand_area(); e = a;
    for (int i = 0; i < NL; i++) begin e[cell_of(i, 0)] = 1'b1; e[cell_of(i, 1)] = 1'b1; end
    set_bounds(0, 15, 0, 15); wr_strobe = '0;
    run_sweep(a, 4'd2, 1, 3);
    n_tests++;
    if (obs_ready !== 1'b1 || obs_aborted !== 1'b1 || obs_cnt !== 16'd3) begin
      n_fail++; $display("FAIL abort_resp: ready=%b aborted=%b cnt=%0d expected 1 1 3", obs_ready, obs_aborted, obs_cnt);
    end
    n_tests++;
    if (obs_area !== e) begin n_fail++; $display("FAIL abort_area: got %h expected %h", obs_area, e); end
    bus.abort = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if (bus.busy !== 1'b0 || bus.req_ready !== 1'b0) begin
      n_fail++; $display("FAIL abort_idle: busy=%b ready=%b expected 0 0", bus.busy, bus.req_ready);
    end
    bus.abort = 1'b0;
    run_sweep(rand_area(), 4'd1, 0, 0);
    n_tests++;
    if (obs_aborted !== 1'b0) begin n_fail++; $display("FAIL abort_clear: got %b expected 0", obs_aborted); end
  endtask

  task automatic test_reset_mid();
    logic seen;
    set_bounds(0, 15, 0, 15); wr_strobe = '0;
    @(negedge clk);
    area_in = rand_area() | {{(NA-1){1'b0}}, 1'b1}; bus.passes = 4'd1; bus.req_valid = 1'b1;
    lane_ready = '0; lane_update = '0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL midreset_busy: got %b expected 1", bus.busy); end
    resetn = 1'b0; bus.req_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.busy !== 1'b0 || area_out !== '0 || cycle_count !== '0 || bus.req_ready !== 1'b0) begin
      n_fail++; $display("FAIL midreset_state: busy=%b area=%h cnt=%0d ready=%b expected 0 0 0 0",
                         bus.busy, area_out, cycle_count, bus.req_ready);
    end
    resetn = 1'b1; seen = 1'b0;
    repeat (12) begin @(negedge clk); seen = seen | bus.req_ready | bus.busy; end
    n_tests++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL midreset_noack: got %b expected 0", seen); end
  endtask

  task automatic test_random();
    int xl, xh, yl, yh;
    for (int t = 0; t < 10; t++) begin
      xl = $urandom_range(0, 15); xh = $urandom_range(0, 15);
      yl = $urandom_range(0, 15); yh = $urandom_range(0, 15);
      if (t < 4) begin xl = 0; xh = 15; yl = 0; yh = 15; end
      set_bounds(xl, xh, yl, yh);
      wr_strobe = {$urandom, $urandom} & {$urandom, $urandom};
      wr_data = {$urandom, $urandom};
      run_sweep(rand_area(), PASS_W'($urandom_range(0, 3)), 0, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : 0);
      n_tests++;
      if (obs_area !== exp_area || lane_mism != 0) begin
        n_fail++; $display("FAIL random_%0d_area: got %h expected %h lane_errs=%0d", t, obs_area, exp_area, lane_mism);
      end
      n_tests++;
      if (obs_cnt !== CNT_W'(exp_cnt) || obs_ready !== 1'b1 || obs_aborted !== exp_aborted) begin
        n_fail++; $display("FAIL random_%0d_resp: cnt=%0d ready=%b ab=%b expected %0d 1 %b",
                           t, obs_cnt, obs_ready, obs_aborted, exp_cnt, exp_aborted);
      end
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.abort = 1'b0; bus.passes = '0;
    area_in = '0; wr_strobe = '0; wr_data = '0;
    lane_ready = '0; lane_update = '0; lane_value = '0;
    set_bounds(0, 15, 0, 15);
    test_reset();
    test_empty_bounds();
    test_full_commit();
    test_lane_stall();
    test_window();
    test_passes();
    test_abort();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
